// File: rtl/issue_scoreboard.sv
// Dual-pipe in-order issue controller: per-register countdown scoreboard,
// intra-pair RAW/WAW blocking and a post-multiply structural gap on the even pipe.
module issue_scoreboard #(
    parameter int unsigned addrWidth = 7,
    parameter int unsigned LAT_ALU   = 2,
    parameter int unsigned LAT_MUL   = 7,
    parameter int unsigned LAT_ODD   = 4,
    parameter int unsigned MUL_GAP   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 evenValid,
    input  logic                 oddValid,
    input  logic [5:0]           opEven,
    input  logic [5:0]           opOdd,
    input  logic [addrWidth-1:0] raEven,
    input  logic [addrWidth-1:0] rbEven,
    input  logic [addrWidth-1:0] rdEven,
    input  logic [addrWidth-1:0] raOdd,
    input  logic [addrWidth-1:0] rbOdd,
    input  logic [addrWidth-1:0] rdOdd,
    input  logic                 immeSelEven,
    input  logic                 immeSelOdd,
    input  logic                 rdWrEven,
    input  logic                 rdWrOdd,
    output logic                 pairReady,
    output logic                 stallOut,
    output logic                 issueEven,
    output logic                 issueOdd,
    output logic [5:0]           issOpEven,
    output logic [5:0]           issOpOdd,
    output logic [addrWidth-1:0] issRdEven,
    output logic [addrWidth-1:0] issRdOdd,
    output logic [15:0]          stallCycles
);

    localparam int unsigned NREG   = 1 << addrWidth;
    localparam int unsigned CW     = 3;
    localparam logic [5:0]  OP_MUL = 6'd20;
    localparam logic [CW-1:0] LD_ALU = CW'(LAT_ALU - 1);
    localparam logic [CW-1:0] LD_MUL = CW'(LAT_MUL - 1);
    localparam logic [CW-1:0] LD_ODD = CW'(LAT_ODD - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(MUL_GAP);

    logic [CW-1:0]          cnt_q [NREG];
    logic [CW-1:0]          cnt_d [NREG];
    logic [CW-1:0]          gap_q, gap_d;
    logic                   even_done_q, even_done_d;
    logic                   odd_done_q, odd_done_d;
    logic                   issue_even_q, issue_even_d;
    logic                   issue_odd_q, issue_odd_d;
    logic [5:0]             iss_op_even_q, iss_op_even_d;
    logic [5:0]             iss_op_odd_q, iss_op_odd_d;
    logic [addrWidth-1:0]   iss_rd_even_q, iss_rd_even_d;
    logic [addrWidth-1:0]   iss_rd_odd_q, iss_rd_odd_d;
    logic [15:0]            stall_cycles_q, stall_cycles_d;

    logic haz_even, haz_odd, intra_haz, even_pend;
    logic can_even, can_odd, pair_ready, stall;

    // Hazard evaluation and issue decision for the current pair
    always_comb begin
        haz_even  = (cnt_q[raEven] != '0)
                  | (~immeSelEven & (cnt_q[rbEven] != '0))
                  | (rdWrEven & (cnt_q[rdEven] != '0));
        haz_odd   = (cnt_q[raOdd] != '0)
                  | (~immeSelOdd & (cnt_q[rbOdd] != '0))
                  | (rdWrOdd & (cnt_q[rdOdd] != '0));
        even_pend = evenValid & ~even_done_q;
        intra_haz = even_pend & rdWrEven
                  & ((rdEven == raOdd)
                   | (~immeSelOdd & (rdEven == rbOdd))
                   | (rdWrOdd & (rdEven == rdOdd)));
        can_even  = even_pend & ~haz_even & (gap_q == '0);
        // Odd never passes even: the older even slot must be done or issuing now
        can_odd   = oddValid & ~odd_done_q & ~haz_odd & ~intra_haz
                  & (even_done_q | can_even | ~evenValid);
        pair_ready = (~evenValid | even_done_q | can_even)
                   & (~oddValid | odd_done_q | can_odd);
        stall      = (evenValid | oddValid) & ~pair_ready;
    end

    // Next-state for scoreboard, gap counter, done flags and registered outputs
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
        end
        gap_d          = (gap_q != '0) ? gap_q - CW'(1) : '0;
        even_done_d    = even_done_q;
        odd_done_d     = odd_done_q;
        issue_even_d   = can_even;
        issue_odd_d    = can_odd;
        iss_op_even_d  = iss_op_even_q;
        iss_op_odd_d   = iss_op_odd_q;
        iss_rd_even_d  = iss_rd_even_q;
        iss_rd_odd_d   = iss_rd_odd_q;
        stall_cycles_d = stall_cycles_q;

        if (can_even) begin
            iss_op_even_d = opEven;
            iss_rd_even_d = rdEven;
            if (rdWrEven) begin
                cnt_d[rdEven] = (opEven == OP_MUL) ? LD_MUL : LD_ALU;
            end
            if (opEven == OP_MUL) begin
                gap_d = GAP_LD;
            end
        end
        if (can_odd) begin
            iss_op_odd_d = opOdd;
            iss_rd_odd_d = rdOdd;
            if (rdWrOdd) begin
                cnt_d[rdOdd] = LD_ODD;
            end
        end

        if (pair_ready) begin
            even_done_d = 1'b0;
            odd_done_d  = 1'b0;
        end else begin
            even_done_d = even_done_q | can_even;
            odd_done_d  = odd_done_q | can_odd;
        end

        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            gap_q          <= '0;
            even_done_q    <= 1'b0;
            odd_done_q     <= 1'b0;
            issue_even_q   <= 1'b0;
            issue_odd_q    <= 1'b0;
            iss_op_even_q  <= '0;
            iss_op_odd_q   <= '0;
            iss_rd_even_q  <= '0;
            iss_rd_odd_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            gap_q          <= gap_d;
            even_done_q    <= even_done_d;
            odd_done_q     <= odd_done_d;
            issue_even_q   <= issue_even_d;
            issue_odd_q    <= issue_odd_d;
            iss_op_even_q  <= iss_op_even_d;
            iss_op_odd_q   <= iss_op_odd_d;
            iss_rd_even_q  <= iss_rd_even_d;
            iss_rd_odd_q   <= iss_rd_odd_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pairReady   = pair_ready;
    assign stallOut    = stall;
    assign issueEven   = issue_even_q;
    assign issueOdd    = issue_odd_q;
    assign issOpEven   = iss_op_even_q;
    assign issOpOdd    = iss_op_odd_q;
    assign issRdEven   = iss_rd_even_q;
    assign issRdOdd    = iss_rd_odd_q;
    assign stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: expected issues queued per slot with expected
// pulse cycle, popped by a monitor; pair latencies and stall counts checked directly.
module tb_issue_scoreboard;

    localparam int unsigned AW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          evenValid, oddValid;
    logic [5:0]    opEven, opOdd;
    logic [AW-1:0] raEven, rbEven, rdEven, raOdd, rbOdd, rdOdd;
    logic          immeSelEven, immeSelOdd, rdWrEven, rdWrOdd;
    logic          pairReady, stallOut, issueEven, issueOdd;
    logic [5:0]    issOpEven, issOpOdd;
    logic [AW-1:0] issRdEven, issRdOdd;
    logic [15:0]   stallCycles;

    issue_scoreboard dut (
        .clk(clk), .reset(reset),
        .evenValid(evenValid), .oddValid(oddValid),
        .opEven(opEven), .opOdd(opOdd),
        .raEven(raEven), .rbEven(rbEven), .rdEven(rdEven),
        .raOdd(raOdd), .rbOdd(rbOdd), .rdOdd(rdOdd),
        .immeSelEven(immeSelEven), .immeSelOdd(immeSelOdd),
        .rdWrEven(rdWrEven), .rdWrOdd(rdWrOdd),
        .pairReady(pairReady), .stallOut(stallOut),
        .issueEven(issueEven), .issueOdd(issueOdd),
        .issOpEven(issOpEven), .issOpOdd(issOpOdd),
        .issRdEven(issRdEven), .issRdOdd(issRdOdd),
        .stallCycles(stallCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    op;
        logic [AW-1:0] rd;
        int            ecyc;
    } exp_t;

    exp_t q_even[$];
    exp_t q_odd[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   exp_stall;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Issue monitor: each pulse must match the oldest expected entry of its slot
    exp_t me, mo;
    always @(negedge clk) begin
        if (issueEven === 1'b1) begin
            if (q_even.size() == 0) begin
                check("even_unexpected_pulse", 32'(issueEven), 32'd0);
            end else begin
                me = q_even.pop_front();
                check("even_op", 32'(issOpEven), 32'(me.op));
                check("even_rd", 32'(issRdEven), 32'(me.rd));
                if (me.ecyc >= 0) check("even_cycle", cyc, me.ecyc);
            end
        end
        if (issueOdd === 1'b1) begin
            if (q_odd.size() == 0) begin
                check("odd_unexpected_pulse", 32'(issueOdd), 32'd0);
            end else begin
                mo = q_odd.pop_front();
                check("odd_op", 32'(issOpOdd), 32'(mo.op));
                check("odd_rd", 32'(issRdOdd), 32'(mo.rd));
                if (mo.ecyc >= 0) check("odd_cycle", cyc, mo.ecyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_even(input logic v, input logic [5:0] op, input logic [AW-1:0] ra,
                            input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                            input logic imm, input logic wr);
        evenValid = v; opEven = op; raEven = ra; rbEven = rb; rdEven = rd;
        immeSelEven = imm; rdWrEven = wr;
    endtask

    task automatic set_odd(input logic v, input logic [5:0] op, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                           input logic imm, input logic wr);
        oddValid = v; opOdd = op; raOdd = ra; rbOdd = rb; rdOdd = rd;
        immeSelOdd = imm; rdWrOdd = wr;
    endtask

    task automatic push_even(input logic [5:0] op, input logic [AW-1:0] rd, input int ecyc);
        exp_t e;
        e.op = op; e.rd = rd; e.ecyc = ecyc;
        q_even.push_back(e);
    endtask

    task automatic push_odd(input logic [5:0] op, input logic [AW-1:0] rd, input int ecyc);
        exp_t e;
        e.op = op; e.rd = rd; e.ecyc = ecyc;
        q_odd.push_back(e);
    endtask

    // Hold the presented pair until pairReady; exp_n = cycles the pair is presented
    task automatic run_pair(input string tag, input int exp_n);
        int n;
        n = 1;
        #1;
        while (pairReady !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
        tick();
        evenValid = 1'b0;
        oddValid  = 1'b0;
    endtask

    int c;

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_even(1'b0, 6'd0, '0, '0, '0, 1'b0, 1'b0);
        set_odd(1'b0, 6'd0, '0, '0, '0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_issue_even", 32'(issueEven), 32'd0);
        check("rst_issue_odd", 32'(issueOdd), 32'd0);
        check("rst_op_even", 32'(issOpEven), 32'd0);
        check("rst_rd_odd", 32'(issRdOdd), 32'd0);
        check("rst_stall_cnt", 32'(stallCycles), 32'd0);
        check("idle_pair_ready", 32'(pairReady), 32'd1);
        check("idle_stall_out", 32'(stallOut), 32'd0);
        reset = 1'b0;
        tick();

        // Independent pair, then readers of both fresh results
        c = cyc;
        set_even(1'b1, 6'd4, 7'd1, 7'd2, 7'd5, 1'b0, 1'b1);
        set_odd(1'b1, 6'd1, 7'd3, 7'd0, 7'd6, 1'b1, 1'b1);
        push_even(6'd4, 7'd5, c + 1); push_odd(6'd1, 7'd6, c + 1);
        run_pair("indep_len", 1);
        set_even(1'b1, 6'd4, 7'd5, 7'd2, 7'd11, 1'b0, 1'b1);
        set_odd(1'b1, 6'd2, 7'd6, 7'd0, 7'd12, 1'b1, 1'b1);
        push_even(6'd4, 7'd11, c + 3); push_odd(6'd2, 7'd12, c + 5);
        run_pair("fwd_len", 4);
        check("stall_after_fwd", 32'(stallCycles), 32'd3);

        // Intra-pair RAW
        c = cyc;
        set_even(1'b1, 6'd4, 7'd1, 7'd2, 7'd10, 1'b0, 1'b1);
        set_odd(1'b1, 6'd1, 7'd10, 7'd0, 7'd13, 1'b1, 1'b1);
        push_even(6'd4, 7'd10, c + 1); push_odd(6'd1, 7'd13, c + 3);
        run_pair("raw_len", 3);
        check("stall_after_raw", 32'(stallCycles), 32'd5);

        // Multiply gap and multiply latency
        c = cyc;
        set_even(1'b1, 6'd20, 7'd1, 7'd2, 7'd7, 1'b0, 1'b1);
        push_even(6'd20, 7'd7, c + 1);
        run_pair("mul_len", 1);
        set_even(1'b1, 6'd4, 7'd3, 7'd4, 7'd8, 1'b0, 1'b1);
        push_even(6'd4, 7'd8, c + 3);
        run_pair("gap_len", 2);
        set_even(1'b1, 6'd4, 7'd7, 7'd1, 7'd9, 1'b0, 1'b1);
        push_even(6'd4, 7'd9, c + 8);
        run_pair("mul_dep_len", 5);
        check("stall_after_mul", 32'(stallCycles), 32'd10);

        // Immediate bypass of a busy rb
        c = cyc;
        set_odd(1'b1, 6'd1, 7'd1, 7'd0, 7'd15, 1'b1, 1'b1);
        push_odd(6'd1, 7'd15, c + 1);
        run_pair("odd_only_len", 1);
        set_even(1'b1, 6'd6, 7'd3, 7'd15, 7'd16, 1'b1, 1'b1);
        push_even(6'd6, 7'd16, c + 2);
        run_pair("imm_len", 1);
        set_even(1'b1, 6'd6, 7'd3, 7'd15, 7'd17, 1'b0, 1'b1);
        push_even(6'd6, 7'd17, c + 5);
        run_pair("rb_busy_len", 3);
        check("stall_after_imm", 32'(stallCycles), 32'd12);

        // Same rd in both slots: WAW on odd
        c = cyc;
        set_even(1'b1, 6'd4, 7'd1, 7'd2, 7'd20, 1'b0, 1'b1);
        set_odd(1'b1, 6'd1, 7'd3, 7'd0, 7'd20, 1'b1, 1'b1);
        push_even(6'd4, 7'd20, c + 1); push_odd(6'd1, 7'd20, c + 3);
        run_pair("waw_len", 3);

        // Gap-blocked even also holds back an independent odd
        c = cyc;
        set_even(1'b1, 6'd20, 7'd1, 7'd2, 7'd21, 1'b0, 1'b1);
        push_even(6'd20, 7'd21, c + 1);
        run_pair("mul2_len", 1);
        set_even(1'b1, 6'd4, 7'd3, 7'd4, 7'd22, 1'b0, 1'b1);
        set_odd(1'b1, 6'd1, 7'd5, 7'd0, 7'd23, 1'b1, 1'b1);
        push_even(6'd4, 7'd22, c + 3); push_odd(6'd1, 7'd23, c + 3);
        run_pair("in_order_len", 2);
        check("stall_after_order", 32'(stallCycles), 32'd15);

        // Reset while odd is pending after even already issued
        c = cyc;
        set_even(1'b1, 6'd20, 7'd1, 7'd2, 7'd24, 1'b0, 1'b1);
        set_odd(1'b1, 6'd1, 7'd24, 7'd0, 7'd25, 1'b1, 1'b1);
        push_even(6'd20, 7'd24, c + 1);
        tick();
        check("mid_pair_ready", 32'(pairReady), 32'd0);
        check("mid_stall_out", 32'(stallOut), 32'd1);
        reset = 1'b1;
        tick();
        q_even.delete(); q_odd.delete();
        check("rst2_issue_even", 32'(issueEven), 32'd0);
        check("rst2_issue_odd", 32'(issueOdd), 32'd0);
        check("rst2_op_even", 32'(issOpEven), 32'd0);
        check("rst2_rd_even", 32'(issRdEven), 32'd0);
        check("rst2_op_odd", 32'(issOpOdd), 32'd0);
        check("rst2_stall_cnt", 32'(stallCycles), 32'd0);
        reset = 1'b0;
        c = cyc;
        push_even(6'd20, 7'd24, c + 1); push_odd(6'd1, 7'd25, c + 8);
        run_pair("represent_len", 8);
        check("stall_after_reset", 32'(stallCycles), 32'd7);

        // Idle: pulses low, fields hold
        tick(); tick();
        check("idle_issue_even", 32'(issueEven), 32'd0);
        check("idle_issue_odd", 32'(issueOdd), 32'd0);
        check("hold_op_even", 32'(issOpEven), 32'd20);
        check("hold_rd_even", 32'(issRdEven), 32'd24);
        check("hold_op_odd", 32'(issOpOdd), 32'd1);
        check("hold_rd_odd", 32'(issRdOdd), 32'd25);

        // Saturation: chained mul/odd pairs, 10 stall cycles per steady pair
        exp_stall = 7;
        for (int k = 0; k < 6600; k++) begin
            set_even(1'b1, 6'd20, 7'd31, 7'd0, 7'd30, 1'b1, 1'b1);
            set_odd(1'b1, 6'd1, 7'd30, 7'd0, 7'd31, 1'b1, 1'b1);
            push_even(6'd20, 7'd30, -1); push_odd(6'd1, 7'd31, -1);
            run_pair("sat_len", (k == 0) ? 8 : 11);
            exp_stall += (k == 0) ? 7 : 10;
            if (exp_stall > 65535) exp_stall = 65535;
            if (k == 6499) check("stall_pre_sat", 32'(stallCycles), 32'(exp_stall));
        end
        check("stall_saturated", 32'(stallCycles), 32'hFFFF);
        tick(); tick();
        check("q_even_drained", 32'(q_even.size()), 32'd0);
        check("q_odd_drained", 32'(q_odd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
